// File: rtl/sort_controller.sv
// Sequences one odd-even sort job: fetch SIZE elements from BRAM into the
// sorter, let it run SIZE phases, then drain the sorted elements back to BRAM.
module sort_controller #(
   parameter int ADDRWIDTH = 4,
   parameter int DATAWIDTH = 8,
   parameter int SIZE      = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   output logic                 busy,
   output logic                 done,
   output logic [ADDRWIDTH-1:0] mem_addr,
   output logic                 mem_write,
   output logic [DATAWIDTH-1:0] mem_wdata,
   input  logic [DATAWIDTH-1:0] mem_rdata,
   output logic                 srt_load,
   output logic                 srt_enable,
   output logic [DATAWIDTH-1:0] srt_in,
   input  logic [DATAWIDTH-1:0] srt_out
);

   typedef enum logic [2:0] {IDLE, FETCH, SORT, DRAIN, DONE} state_t;

   localparam logic [ADDRWIDTH:0] CNT_SIZE = (ADDRWIDTH+1)'(SIZE);
   localparam logic [ADDRWIDTH:0] CNT_LAST = (ADDRWIDTH+1)'(SIZE - 1);
   localparam logic [ADDRWIDTH:0] CNT_ONE  = (ADDRWIDTH+1)'(1);

   state_t               state_reg, state_next;
   logic [ADDRWIDTH:0]   cnt_reg, cnt_next;
   logic                 busy_next, done_next, load_next, drain_next;
   logic [ADDRWIDTH-1:0] addr_next;

   // Data moves straight through; only control is registered.
   assign srt_in    = mem_rdata;
   assign mem_wdata = srt_out;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = FETCH;
               cnt_next   = '0;
            end
         end
         FETCH: begin
            if (abort) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else if (cnt_reg == CNT_SIZE) begin
               state_next = SORT;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CNT_ONE;
            end
         end
         SORT: begin
            if (abort) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
               state_next = DRAIN;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CNT_ONE;
            end
         end
         DRAIN: begin
            if (abort) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
               state_next = DONE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CNT_ONE;
            end
         end
         DONE: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so the flops hold the value
   // belonging to the state they will be in during the coming cycle.
   always_comb begin
      busy_next  = (state_next != IDLE);
      done_next  = (state_next == DONE);
      load_next  = (state_next == FETCH) && (cnt_next != '0);
      drain_next = (state_next == DRAIN);
      addr_next  = '0;
      if ((state_next == FETCH) && (cnt_next < CNT_SIZE)) begin
         addr_next = cnt_next[ADDRWIDTH-1:0];
      end else if (state_next == DRAIN) begin
         addr_next = cnt_next[ADDRWIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         srt_load   <= 1'b0;
         srt_enable <= 1'b0;
         mem_write  <= 1'b0;
         mem_addr   <= '0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         busy       <= busy_next;
         done       <= done_next;
         srt_load   <= load_next;
         srt_enable <= drain_next;
         mem_write  <= drain_next;
         mem_addr   <= addr_next;
      end
   end

endmodule

// File: tb/tb_sort_controller.sv
// Bench for sort_controller with a BRAM model, an odd-even sorter model and
// a reference built from the job timeline and a plain queue sort.
module tb_sort_controller;
   localparam int AW = 4;
   localparam int DW = 8;
   localparam int N  = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          busy, done, mem_write, srt_load, srt_enable;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata, srt_in, srt_out;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sort_controller #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .SIZE(N)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .busy(busy), .done(done),
      .mem_addr(mem_addr), .mem_write(mem_write), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .srt_load(srt_load), .srt_enable(srt_enable),
      .srt_in(srt_in), .srt_out(srt_out)
   );

   // BRAM with registered read and a bench-side preload port
   logic [DW-1:0] mem [N];
   logic          tb_we = 1'b0;
   logic [AW-1:0] tb_addr = '0;
   logic [DW-1:0] tb_data = '0;
   always @(posedge clk) begin
      if (tb_we) mem[tb_addr] <= tb_data;
      else if (mem_write) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   // Odd-even transposition sorter: loads append, idle cycles run a phase,
   // enable advances the read index.
   logic [DW-1:0] sarr [N];
   int            lidx = 0;
   int            sidx = 0;
   int            p;
   logic          phase = 1'b0;
   logic          prev_load = 1'b0;
   assign srt_out = (sidx < N) ? sarr[sidx] : '0;
   always @(posedge clk) begin
      if (srt_load) begin
         if (!prev_load) begin
            sarr[0] <= srt_in;
            lidx <= 1;
         end else if (lidx < N) begin
            sarr[lidx] <= srt_in;
            lidx <= lidx + 1;
         end
      end else if (srt_enable) begin
         sidx <= sidx + 1;
      end else begin
         if (prev_load) begin
            sidx <= 0;
            p = 0;
            phase <= 1'b1;
         end else begin
            p = int'(phase);
            phase <= ~phase;
         end
         for (int i = p; i + 1 < N; i += 2) begin
            if (sarr[i] > sarr[i+1]) begin
               sarr[i]   <= sarr[i+1];
               sarr[i+1] <= sarr[i];
            end
         end
      end
      prev_load <= srt_load;
   end

   logic [DW-1:0] pat [N];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic preload();
      for (int i = 0; i < N; i++) begin
         tb_we = 1'b1;
         tb_addr = AW'(i);
         tb_data = pat[i];
         step();
      end
      tb_we = 1'b0;
   endtask

   // cut>0: abort (or reset when is_rst) is driven during cycle cut.
   // sa/sb: extra start pulses. noisy: abort with start and again in DONE.
   task automatic run_job(input string name, input int cut, input bit is_rst,
                          input int sa, input int sb, input bit noisy);
      logic [DW-1:0] snap [N];
      logic [DW-1:0] q [$];
      int writes, dones, ph, k, eb, ed, el, ew, ea, exp_writes;
      bit full;
      writes = 0;
      dones  = 0;
      full   = (cut == 0);
      q.delete();
      for (int i = 0; i < N; i++) begin
         snap[i] = mem[i];
         q.push_back(mem[i]);
      end
      q.sort();
      start = 1'b1;
      abort = noisy;
      step();
      for (int c = 1; c <= 3*N + 6; c++) begin
         start = (c == sa) || (c == sb);
         abort = (!is_rst && c == cut) || (noisy && c == 3*N + 2);
         rst   = (is_rst && c == cut);
         // 0 idle, 1 fetch, 2 sort, 3 drain, 4 done
         if (cut > 0 && c > cut) ph = 0;
         else if (c <= N + 1) ph = 1;
         else if (c <= 2*N + 1) ph = 2;
         else if (c <= 3*N + 1) ph = 3;
         else if (c == 3*N + 2) ph = 4;
         else ph = 0;
         k  = c - 1;
         eb = (ph != 0) ? 1 : 0;
         ed = (ph == 4) ? 1 : 0;
         el = (ph == 1 && k >= 1) ? 1 : 0;
         ew = (ph == 3) ? 1 : 0;
         ea = (ph == 1 && k < N) ? k : (ph == 3) ? c - (2*N + 2) : 0;
         chk($sformatf("%s c%0d busy", name, c), 32'(busy), 32'(eb));
         chk($sformatf("%s c%0d done", name, c), 32'(done), 32'(ed));
         chk($sformatf("%s c%0d srt_load", name, c), 32'(srt_load), 32'(el));
         chk($sformatf("%s c%0d srt_enable", name, c), 32'(srt_enable), 32'(ew));
         chk($sformatf("%s c%0d mem_write", name, c), 32'(mem_write), 32'(ew));
         chk($sformatf("%s c%0d mem_addr", name, c), 32'(mem_addr), 32'(ea));
         if (mem_write) writes++;
         if (done) dones++;
         step();
      end
      start = 1'b0;
      abort = 1'b0;
      rst   = 1'b0;
      if (full) exp_writes = N;
      else if (cut > 3*N + 1) exp_writes = N;
      else if (cut > 2*N + 1) exp_writes = cut - (2*N + 1);
      else exp_writes = 0;
      chk($sformatf("%s write_cycles", name), 32'(writes), 32'(exp_writes));
      chk($sformatf("%s done_pulses", name), 32'(dones), full ? 32'd1 : 32'd0);
      if (full) begin
         for (int i = 0; i < N; i++)
            chk($sformatf("%s mem[%0d]", name, i), 32'(mem[i]), 32'(q[i]));
      end else if (!is_rst) begin
         for (int i = 0; i < N; i++)
            chk($sformatf("%s untouched[%0d]", name, i), 32'(mem[i]), 32'(snap[i]));
      end
      $display("job %s: done_pulses=%0d write_cycles=%0d", name, dones, writes);
   endtask

   task automatic rand_pat();
      for (int i = 0; i < N; i++) pat[i] = DW'($urandom_range(0, 255));
   endtask

   initial begin
      rst = 1'b1;
      step();
      step();
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset srt_load", 32'(srt_load), 32'd0);
      chk("reset srt_enable", 32'(srt_enable), 32'd0);
      chk("reset mem_write", 32'(mem_write), 32'd0);
      chk("reset mem_addr", 32'(mem_addr), 32'd0);
      rst = 1'b0;
      step();

      for (int i = 0; i < N; i++) pat[i] = DW'(N - 1 - i);
      preload();
      run_job("reverse", 0, 1'b0, 0, 0, 1'b0);

      pat[0] = 8'd7; pat[1] = 8'd7; pat[2] = 8'd3; pat[3] = 8'd200;
      pat[4] = 8'd0; pat[5] = 8'd255; pat[6] = 8'd3;
      for (int i = 7; i < N; i++)
         pat[i] = (i % 2 == 1) ? pat[$urandom_range(0, 6)] : DW'($urandom_range(0, 255));
      preload();
      run_job("dups", 0, 1'b0, 0, 0, 1'b0);

      rand_pat();
      preload();
      run_job("restart_ignored", 0, 1'b0, 10, 3*N + 2, 1'b0);

      rand_pat();
      preload();
      run_job("abort_sort", 25, 1'b0, 0, 0, 1'b0);
      run_job("after_abort", 0, 1'b0, 0, 0, 1'b0);

      rand_pat();
      preload();
      run_job("rst_drain", 40, 1'b1, 0, 0, 1'b0);
      run_job("after_rst", 0, 1'b0, 0, 0, 1'b0);

      for (int i = 0; i < N; i++) pat[i] = DW'(i);
      preload();
      run_job("presorted", 0, 1'b0, 0, 0, 1'b0);

      rand_pat();
      preload();
      run_job("abort_idle_done", 0, 1'b0, 0, 0, 1'b1);

      rand_pat();
      preload();
      run_job("abort_fetch", 9, 1'b0, 0, 0, 1'b0);

      for (int j = 0; j < 3; j++) begin
         for (int i = 0; i < N; i++) pat[i] = DW'($urandom_range(0, 7));
         preload();
         run_job($sformatf("random%0d", j), 0, 1'b0, 0, 0, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/sort_controller.md
SORT_CONTROLLER -- requirements
Module: sort_controller

Interface
REQ-001 The block SHALL have parameter ADDRWIDTH, default 4, giving the memory and sorter address width.
REQ-002 The block SHALL have parameter DATAWIDTH, default 8, giving the element width.
REQ-003 The block SHALL have parameter SIZE, default 16, giving the element count, with SIZE = 2**ADDRWIDTH and SIZE even.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port start, input, 1 bit: request one sort job; sampled only in IDLE.
REQ-007 The block SHALL have port abort, input, 1 bit: cancel the job in progress.
REQ-008 The block SHALL have port busy, output, 1 bit: high in every state other than IDLE.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse when the job completes.
REQ-010 The block SHALL have port mem_addr, output, ADDRWIDTH bits: single-port BRAM address.
REQ-011 The block SHALL have port mem_write, output, 1 bit: BRAM write enable.
REQ-012 The block SHALL have port mem_wdata, output, DATAWIDTH bits: BRAM write data.
REQ-013 The block SHALL have port mem_rdata, input, DATAWIDTH bits: BRAM read data, valid 1 cycle after address with mem_write=0.
REQ-014 The block SHALL have ports srt_load and srt_enable, output, 1 bit each: odd-even sorter load and read-advance strobes.
REQ-015 The block SHALL have port srt_in, output, DATAWIDTH bits: sorter load data.
REQ-016 The block SHALL have port srt_out, input, DATAWIDTH bits: sorter element at the sorter's internal index.

Function
REQ-017 The block SHALL implement states IDLE, FETCH, SORT, DRAIN, DONE, with one internal counter cnt of ADDRWIDTH+1 bits.
REQ-018 IDLE SHALL drive srt_load=0, srt_enable=0 and mem_write=0; start=1 moves to FETCH with cnt=0.
REQ-019 FETCH SHALL last SIZE+1 cycles (cnt 0..SIZE), drive mem_addr=cnt[ADDRWIDTH-1:0] while cnt<SIZE, and drive srt_load=1 while cnt>=1.
REQ-020 srt_in SHALL equal mem_rdata combinationally, so element k loads on FETCH cycle cnt=k+1.
REQ-021 SORT SHALL last exactly SIZE cycles with srt_load=0, srt_enable=0 and mem_write=0, letting the sorter alternate even/odd phases; its first SORT cycle also zeroes the sorter index.
REQ-022 DRAIN SHALL last SIZE cycles, driving mem_write=1, mem_addr=cnt and srt_enable=1.
REQ-023 In DRAIN, mem_wdata SHALL equal srt_out combinationally, so sorted element k is written to address k.
REQ-024 DONE SHALL last 1 cycle with done=1 and all strobes 0, then return to IDLE.
REQ-025 Timing SHALL be fixed: with start sampled at edge 0, done SHALL be high in cycle 3*SIZE+2, i.e. cycle 50 for SIZE=16.
REQ-026 start while busy=1, including in DONE, SHALL be ignored and not queued.
REQ-027 abort=1 in FETCH, SORT or DRAIN SHALL return the block to IDLE next cycle with all strobes 0 and no done pulse; abort in IDLE or DONE SHALL have no effect.
REQ-028 abort and start in the same IDLE cycle SHALL start the job (abort is ignored in IDLE).
REQ-029 All control outputs SHALL be decoded from registered state and cnt only; mem_rdata->srt_in and srt_out->mem_wdata SHALL be the only combinational paths.
REQ-030 When mem_write=0 and the block is not in FETCH, mem_addr SHALL be 0.
REQ-031 Sort order SHALL be ascending unsigned; equal keys are permitted, and stability is not required.

Reset
REQ-032 rst=1 at a clock edge SHALL force IDLE, cnt=0, busy=0, done=0, srt_load=0, srt_enable=0, mem_write=0 and mem_addr=0, overriding start and abort.
REQ-033 Reset mid-job SHALL discard the job, and the next start SHALL run a complete job from FETCH.

Verification
REQ-034 BRAM loaded with 15..0, then start -> BRAM reads 0..15 at addresses 0..15; done in cycle 50; busy high for cycles 1..50.
REQ-035 BRAM loaded with {7,7,3,200,0,255,3,...} containing duplicates -> ascending output with duplicates preserved in count; exactly one done pulse.
REQ-036 start pulsed again at cycles 10 and 50 -> ignored; only one job runs and only one done pulse occurs.
REQ-037 abort at cycle 25 (SORT) -> busy=0 at cycle 26; no done pulse; no BRAM writes occur; a new start then completes normally.
REQ-038 rst asserted at cycle 40 (DRAIN) -> all outputs 0 next cycle; a following start yields a correctly sorted BRAM.
REQ-039 Already-sorted input 0..15 -> output unchanged; mem_write asserted exactly 16 cycles.
